// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment controller with a CPU-writable 32-bit value register.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module seg7_scan_ctrl #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Seg_we,
    input  logic [31:0] wdata,
    output logic [31:0] value_q,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;
    logic [2:0]    idx;
    logic [3:0]    nibble;
    logic [7:0]    hex_code;
    logic          blank;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_comb begin
        nibble   = 4'(value_q >> {idx, 2'b00});
        hex_code = hex_to_seg(nibble);
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [7:0] lead_zero;

    // lead_zero[i]: nibbles i..7 are all zero; digit 0 never blanks.
    always_comb begin
        lead_zero = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            lead_zero[i] = ((value_q >> (4 * i)) == '0);
        end
        blank = lead_zero[idx];
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else if (Seg_we) begin
            value_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            idx <= idx + 3'd1;
        end else begin
            div <= div + DW'(1);
        end
    end

    // Output stage samples the pre-edge idx/value_q, so an and seg always move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 8'hFE;
            seg <= 8'hC0;
        end else begin
            an  <= ~(8'd1 << idx);
            seg <= blank ? 8'hFF : hex_code;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized self-checking bench: CLK_DIV=4 and CLK_DIV=1 instances against a time-based scan model.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        Seg_we;
    logic [31:0] wdata;
    logic [31:0] value_q4, value_q1;
    logic [7:0]  an4, an1, seg4, seg1;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    localparam int DIVS [2] = '{4, 1};

    logic [31:0] mval;
    int          mt [2];
    logic [7:0]  e_an [2];
    logic [7:0]  e_seg [2];

    seg7_scan_ctrl #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .Seg_we(Seg_we), .wdata(wdata),
        .value_q(value_q4), .an(an4), .seg(seg4)
    );

    seg7_scan_ctrl #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .Seg_we(Seg_we), .wdata(wdata),
        .value_q(value_q1), .an(an1), .seg(seg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_seg(input logic [31:0] v, input int digit);
        logic [31:0] upper;
        int          n;
        upper = v >> (4 * digit);
        n = int'(upper & 32'hF);
`ifdef SEG7_LZ_BLANK_EN
        if (digit != 0 && upper == 32'd0) return 8'hFF;
`endif
        return HEX[n];
    endfunction

    // Drive one cycle: expected outputs come from the elapsed-time model before the edge.
    task automatic tick(input bit r, input bit we, input logic [31:0] d);
        int digit;
        rst = r; Seg_we = we; wdata = d;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                e_an[k]  = 8'hFE;
                e_seg[k] = 8'hC0;
            end else begin
                digit    = (mt[k] / DIVS[k]) % 8;
                e_an[k]  = ~(8'd1 << digit);
                e_seg[k] = model_seg(mval, digit);
            end
            mt[k] = r ? 0 : mt[k] + 1;
        end
        if (r) mval = 32'd0;
        else if (we) mval = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, 32'hDEADBEEF);
        tick(1, 0, 32'h0);
        checks++;
        if (an4 !== 8'hFE) begin errors++; $display("FAIL reset_an got=%h exp=FE", an4); end
        checks++;
        if (seg4 !== 8'hC0) begin errors++; $display("FAIL reset_seg got=%h exp=C0", seg4); end
        checks++;
        if (value_q4 !== 32'd0) begin errors++; $display("FAIL reset_value got=%h exp=0", value_q4); end
        checks++;
        if (an1 !== 8'hFE || seg1 !== 8'hC0 || value_q1 !== 32'd0) begin
            errors++; $display("FAIL reset_div1 an=%h seg=%h val=%h exp FE C0 0", an1, seg1, value_q1);
        end
    endtask

    task automatic test_write();
        tick(0, 1, 32'h12345678);
        checks++;
        if (value_q4 !== 32'h12345678) begin
            errors++; $display("FAIL write_value got=%h exp=12345678", value_q4);
        end
        tick(0, 0, $urandom);
        checks++;
        if (seg4 !== 8'h80 || seg4 !== e_seg[0]) begin
            errors++; $display("FAIL write_seg got=%h exp=80 model=%h", seg4, e_seg[0]);
        end
    endtask

    task automatic test_scan();
        for (int c = 0; c < 32; c++) begin
            tick(0, 0, 32'h0);
            checks++;
            if (an4 !== e_an[0] || seg4 !== e_seg[0]) begin
                errors++; $display("FAIL scan c=%0d an=%h seg=%h exp an=%h seg=%h", c, an4, seg4, e_an[0], e_seg[0]);
            end
            if (e_an[0] == 8'h7F) begin
                checks++;
                if (seg4 !== 8'hF9) begin errors++; $display("FAIL scan_digit7 seg=%h exp=F9", seg4); end
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] held;
        held = mval;
        for (int c = 0; c < 32; c++) begin
            tick(0, 0, $urandom);
            checks++;
            if (value_q4 !== held || an4 !== e_an[0] || seg4 !== e_seg[0]) begin
                errors++; $display("FAIL hold c=%0d val=%h an=%h seg=%h exp val=%h an=%h seg=%h",
                                   c, value_q4, an4, seg4, held, e_an[0], e_seg[0]);
            end
        end
    endtask

    task automatic test_reset_midscan();
        bit found;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick(0, 0, 32'h0);
            if (e_an[0] == 8'hDF) found = 1'b1;
        end
        checks++;
        if (!found || an4 !== 8'hDF) begin
            errors++; $display("FAIL midscan_reach an=%h exp=DF found=%0d", an4, found);
        end
        tick(1, 0, 32'h0);
        checks++;
        if (an4 !== 8'hFE || seg4 !== 8'hC0 || value_q4 !== 32'd0) begin
            errors++; $display("FAIL midscan_reset an=%h seg=%h val=%h exp FE C0 0", an4, seg4, value_q4);
        end
        for (int c = 0; c < 12; c++) begin
            tick(0, 0, 32'h0);
            checks++;
            if (an4 !== e_an[0] || seg4 !== e_seg[0]) begin
                errors++; $display("FAIL midscan_restart c=%0d an=%h seg=%h exp an=%h seg=%h", c, an4, seg4, e_an[0], e_seg[0]);
            end
        end
    endtask

    task automatic test_blank();
        tick(0, 1, 32'h000000A0);
        for (int c = 0; c < 40; c++) begin
            tick(0, 0, $urandom);
            checks++;
            if (an4 !== e_an[0] || seg4 !== e_seg[0]) begin
                errors++; $display("FAIL blank c=%0d an=%h seg=%h exp an=%h seg=%h", c, an4, seg4, e_an[0], e_seg[0]);
            end
            if (e_an[0] == 8'hFD) begin
                checks++;
                if (seg4 !== 8'h88) begin errors++; $display("FAIL blank_digit1 seg=%h exp=88", seg4); end
            end
        end
    endtask

    task automatic test_div1();
        logic [7:0] prev;
        tick(0, 1, 32'hFEDCBA98);
        prev = an1;
        for (int c = 0; c < 16; c++) begin
            tick(0, 0, 32'h0);
            checks++;
            if (an1 !== e_an[1] || seg1 !== e_seg[1] || an1 === prev) begin
                errors++; $display("FAIL div1 c=%0d an=%h seg=%h exp an=%h seg=%h prev_an=%h", c, an1, seg1, e_an[1], e_seg[1], prev);
            end
            prev = an1;
        end
    endtask

    task automatic test_random();
        bit r, we;
        for (int c = 0; c < 300; c++) begin
            r  = ($urandom_range(0, 49) == 0);
            we = ($urandom_range(0, 5) == 0);
            tick(r, we, ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000FFFF) : $urandom);
            checks++;
            if (value_q4 !== mval || value_q1 !== mval) begin
                errors++; $display("FAIL rand_value c=%0d v4=%h v1=%h exp=%h", c, value_q4, value_q1, mval);
            end
            checks++;
            if (an4 !== e_an[0] || seg4 !== e_seg[0] || an1 !== e_an[1] || seg1 !== e_seg[1]) begin
                errors++; $display("FAIL rand_out c=%0d an4=%h seg4=%h an1=%h seg1=%h exp %h %h %h %h",
                                   c, an4, seg4, an1, seg1, e_an[0], e_seg[0], e_an[1], e_seg[1]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; Seg_we = 1'b0; wdata = '0;
        mval = '0; mt[0] = 0; mt[1] = 0;
        #1;
        test_reset();
        test_write();
        test_scan();
        test_hold();
        test_reset_midscan();
        test_blank();
        test_div1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
